// File: rtl/counter_b32_sched_if.sv
// ============================================================================
// Module   : counter_b32_sched_if
// Purpose  : Requester command/grant bundle and counter control bus for
//            counter_b32_sched.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface counter_b32_sched_if #(
   parameter int LEN_W  = 8,
   parameter int DATA_W = 32
);
   logic              ctl_req0;
   logic [1:0]        ctl_cmd0_mode;
   logic [DATA_W-1:0] ctl_cmd0_D;
   logic [LEN_W-1:0]  ctl_cmd0_len;
   logic              ctl_req1;
   logic [1:0]        ctl_cmd1_mode;
   logic [DATA_W-1:0] ctl_cmd1_D;
   logic [LEN_W-1:0]  ctl_cmd1_len;
   logic [7:0]        ctl_rco;

   logic              ctl_gnt0;
   logic              ctl_gnt1;
   logic              ctl_done0;
   logic              ctl_done1;
   logic              ctl_abort;
   logic              ctl_busy;
   logic              ctl_enable;
   logic [1:0]        ctl_mode;
   logic [DATA_W-1:0] ctl_D;

   modport master (
      output ctl_req0, ctl_cmd0_mode, ctl_cmd0_D, ctl_cmd0_len,
      output ctl_req1, ctl_cmd1_mode, ctl_cmd1_D, ctl_cmd1_len,
      output ctl_rco,
      input  ctl_gnt0, ctl_gnt1, ctl_done0, ctl_done1, ctl_abort,
      input  ctl_busy, ctl_enable, ctl_mode, ctl_D
   );

   modport slave (
      input  ctl_req0, ctl_cmd0_mode, ctl_cmd0_D, ctl_cmd0_len,
      input  ctl_req1, ctl_cmd1_mode, ctl_cmd1_D, ctl_cmd1_len,
      input  ctl_rco,
      output ctl_gnt0, ctl_gnt1, ctl_done0, ctl_done1, ctl_abort,
      output ctl_busy, ctl_enable, ctl_mode, ctl_D
   );
endinterface

`default_nettype wire

// File: rtl/counter_b32_sched.sv
// ============================================================================
// Module   : counter_b32_sched
// Purpose  : Round-robin command scheduler driving a sliced 32-bit counter.
//            Optional macro CTL_RCO_ABORT_EN ends a run early on any ctl_rco.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_b32_sched #(
   parameter int LEN_W  = 8,
   parameter int DATA_W = 32
) (
   input  wire logic          ctl_clk,
   input  wire logic          ctl_reset,
   counter_b32_sched_if.slave bus
);

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                rr_last_q, rr_last_d;
   logic                owner_q, owner_d;
   logic [1:0]          cmd_mode_q, cmd_mode_d;
   logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
   logic [LEN_W-1:0]    cmd_len_q, cmd_len_d;
   logic [LEN_W-1:0]    remain_q, remain_d;
   logic                aborted_q, aborted_d;

   logic                gnt0_q, gnt0_d;
   logic                gnt1_q, gnt1_d;
   logic                done0_q, done0_d;
   logic                done1_q, done1_d;
   logic                abort_q, abort_d;
   logic                busy_q, busy_d;
   logic                enable_q, enable_d;
   logic [1:0]          mode_q, mode_d;
   logic [DATA_W-1:0]   data_q, data_d;

   logic                pick;
   logic                rco_hit;

`ifdef CTL_RCO_ABORT_EN
   assign rco_hit = |bus.ctl_rco;
`else
   logic rco_unused;
   assign rco_unused = ^bus.ctl_rco;
   assign rco_hit    = 1'b0;
`endif

   // Contention goes to whoever was not served last; otherwise the sole requester.
   always_comb begin
      pick = 1'b0;
      if (bus.ctl_req0 && bus.ctl_req1) begin
         pick = ~rr_last_q;
      end else begin
         pick = bus.ctl_req1;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      owner_d    = owner_q;
      cmd_mode_d = cmd_mode_q;
      cmd_data_d = cmd_data_q;
      cmd_len_d  = cmd_len_q;
      remain_d   = remain_q;
      aborted_d  = aborted_q;

      unique case (state_q)
         ST_IDLE: begin
            aborted_d = 1'b0;
            if (bus.ctl_req0 || bus.ctl_req1) begin
               owner_d   = pick;
               rr_last_d = pick;
               state_d   = ST_LOAD;
               if (pick) begin
                  cmd_mode_d = bus.ctl_cmd1_mode;
                  cmd_data_d = bus.ctl_cmd1_D;
                  cmd_len_d  = bus.ctl_cmd1_len;
               end else begin
                  cmd_mode_d = bus.ctl_cmd0_mode;
                  cmd_data_d = bus.ctl_cmd0_D;
                  cmd_len_d  = bus.ctl_cmd0_len;
               end
            end
         end
         ST_LOAD: begin
            if ((cmd_mode_q == MODE_LOAD) || (cmd_len_q == '0)) begin
               state_d = ST_DONE;
            end else begin
               state_d  = ST_RUN;
               remain_d = cmd_len_q;
            end
         end
         ST_RUN: begin
            remain_d = remain_q - LEN_W'(1);
            if (rco_hit) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else if (remain_q == LEN_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are precomputed from the next state so they appear registered
   // in the same cycle the FSM enters that state.
   always_comb begin
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      abort_d  = 1'b0;
      busy_d   = (state_d != ST_IDLE);
      enable_d = 1'b0;
      mode_d   = MODE_UP;
      data_d   = '0;

      unique case (state_d)
         ST_LOAD: begin
            gnt0_d   = ~owner_d;
            gnt1_d   = owner_d;
            enable_d = 1'b1;
            mode_d   = MODE_LOAD;
            data_d   = cmd_data_d;
         end
         ST_RUN: begin
            enable_d = 1'b1;
            mode_d   = cmd_mode_d;
            data_d   = cmd_data_d;
         end
         ST_DONE: begin
            done0_d = ~owner_d;
            done1_d = owner_d;
            abort_d = aborted_d;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge ctl_clk) begin
      if (ctl_reset) begin
         state_q    <= ST_IDLE;
         rr_last_q  <= 1'b1;
         owner_q    <= 1'b0;
         cmd_mode_q <= '0;
         cmd_data_q <= '0;
         cmd_len_q  <= '0;
         remain_q   <= '0;
         aborted_q  <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         abort_q    <= 1'b0;
         busy_q     <= 1'b0;
         enable_q   <= 1'b0;
         mode_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         owner_q    <= owner_d;
         cmd_mode_q <= cmd_mode_d;
         cmd_data_q <= cmd_data_d;
         cmd_len_q  <= cmd_len_d;
         remain_q   <= remain_d;
         aborted_q  <= aborted_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         abort_q    <= abort_d;
         busy_q     <= busy_d;
         enable_q   <= enable_d;
         mode_q     <= mode_d;
         data_q     <= data_d;
      end
   end

   assign bus.ctl_gnt0   = gnt0_q;
   assign bus.ctl_gnt1   = gnt1_q;
   assign bus.ctl_done0  = done0_q;
   assign bus.ctl_done1  = done1_q;
   assign bus.ctl_abort  = abort_q;
   assign bus.ctl_busy   = busy_q;
   assign bus.ctl_enable = enable_q;
   assign bus.ctl_mode   = mode_q;
   assign bus.ctl_D      = data_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_b32_sched.sv
// ============================================================================
// Module   : tb_counter_b32_sched
// Purpose  : Self-checking bench for counter_b32_sched (honours CTL_RCO_ABORT_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter_b32_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   counter_b32_sched_if #(.LEN_W(8), .DATA_W(32)) bus ();

   counter_b32_sched #(.LEN_W(8), .DATA_W(32)) dut (
      .ctl_clk   (clk),
      .ctl_reset (rst),
      .bus       (bus.slave)
   );

   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] d;
      logic [7:0]  len;
   } cmd_t;

   typedef struct {
      logic        gnt0, gnt1, done0, done1, abort, busy, en;
      logic [1:0]  mode;
      logic [31:0] d;
      bit          is_run;
      bit          owner;
   } exp_t;

   cmd_t q0[$];
   cmd_t q1[$];
   exp_t exp_q[$];

   int  n_assert = 0;
   int  n_fail   = 0;
   int  cyc      = 0;
   bit  m_valid  = 1'b0;
   bit  m_rr_last = 1'b1;
   int  done0_cnt = 0;
   int  done1_cnt = 0;
   int  abort_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t blank();
      exp_t e;
      e.gnt0 = 0; e.gnt1 = 0; e.done0 = 0; e.done1 = 0; e.abort = 0;
      e.busy = 0; e.en = 0; e.mode = 2'b00; e.d = '0; e.is_run = 0; e.owner = 0;
      return e;
   endfunction

   function automatic exp_t mk_done(input bit own, input bit ab);
      exp_t e = blank();
      e.done0 = !own; e.done1 = own; e.abort = ab; e.busy = 1; e.owner = own;
      return e;
   endfunction

   // Whole-command timeline: one load cycle, len counting cycles, one done cycle.
   task automatic plan(input bit own, input logic [1:0] m, input logic [31:0] d, input logic [7:0] l);
      exp_t e = blank();
      e.gnt0 = !own; e.gnt1 = own; e.busy = 1; e.en = 1; e.mode = 2'b11; e.d = d; e.owner = own;
      exp_q.push_back(e);
      if (m != 2'b11) begin
         for (int i = 0; i < int'(l); i++) begin
            e = blank();
            e.busy = 1; e.en = 1; e.mode = m; e.d = d; e.is_run = 1; e.owner = own;
            exp_q.push_back(e);
         end
      end
      exp_q.push_back(mk_done(own, 1'b0));
   endtask

   // Model: advances one cycle per rising edge from the sampled inputs.
   initial begin
      exp_t e;
      bit   own;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            exp_q.delete();
            m_rr_last = 1'b1;
            m_valid   = 1'b1;
         end else if (exp_q.size() == 0) begin
            if (bus.ctl_req0 || bus.ctl_req1) begin
               own = (bus.ctl_req0 && bus.ctl_req1) ? !m_rr_last : bus.ctl_req1;
               m_rr_last = own;
               if (own) plan(1'b1, bus.ctl_cmd1_mode, bus.ctl_cmd1_D, bus.ctl_cmd1_len);
               else     plan(1'b0, bus.ctl_cmd0_mode, bus.ctl_cmd0_D, bus.ctl_cmd0_len);
            end
         end else begin
            e = exp_q.pop_front();
`ifdef CTL_RCO_ABORT_EN
            if (e.is_run && (bus.ctl_rco != 8'h00)) begin
               exp_q.delete();
               exp_q.push_back(mk_done(e.owner, 1'b1));
            end
`endif
         end
      end
   end

   // Compare every cycle once the model has seen reset.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            e = (exp_q.size() > 0) ? exp_q[0] : blank();
            chk("gnt",    {bus.ctl_gnt1, bus.ctl_gnt0},   {e.gnt1, e.gnt0});
            chk("done",   {bus.ctl_done1, bus.ctl_done0}, {e.done1, e.done0});
            chk("abort",  bus.ctl_abort,  e.abort);
            chk("busy",   bus.ctl_busy,   e.busy);
            chk("enable", bus.ctl_enable, e.en);
            chk("mode",   bus.ctl_mode,   e.mode);
            chk("D",      bus.ctl_D,      e.d);
            done0_cnt += int'(bus.ctl_done0);
            done1_cnt += int'(bus.ctl_done1);
            abort_cnt += int'(bus.ctl_abort);
         end
      end
   end

   // Requester agents: hold each command until its grant is seen.
   initial begin
      bus.ctl_req0 = 0; bus.ctl_cmd0_mode = 0; bus.ctl_cmd0_D = 0; bus.ctl_cmd0_len = 0;
      forever begin
         @(negedge clk);
         if (bus.ctl_gnt0 && q0.size() > 0) void'(q0.pop_front());
         if (q0.size() > 0) begin
            bus.ctl_req0 = 1; bus.ctl_cmd0_mode = q0[0].mode;
            bus.ctl_cmd0_D = q0[0].d; bus.ctl_cmd0_len = q0[0].len;
         end else begin
            bus.ctl_req0 = 0;
         end
      end
   end

   initial begin
      bus.ctl_req1 = 0; bus.ctl_cmd1_mode = 0; bus.ctl_cmd1_D = 0; bus.ctl_cmd1_len = 0;
      forever begin
         @(negedge clk);
         if (bus.ctl_gnt1 && q1.size() > 0) void'(q1.pop_front());
         if (q1.size() > 0) begin
            bus.ctl_req1 = 1; bus.ctl_cmd1_mode = q1[0].mode;
            bus.ctl_cmd1_D = q1[0].d; bus.ctl_cmd1_len = q1[0].len;
         end else begin
            bus.ctl_req1 = 0;
         end
      end
   end

   task automatic push_cmd(input int r, input logic [1:0] m, input logic [31:0] d, input logic [7:0] l);
      cmd_t c;
      c.mode = m; c.d = d; c.len = l;
      if (r == 0) q0.push_back(c);
      else        q1.push_back(c);
   endtask

   task automatic wait_any_gnt(output int id, output int c);
      bit got = 0;
      id = -1; c = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (bus.ctl_gnt0 || bus.ctl_gnt1) begin
            got = 1; id = bus.ctl_gnt1 ? 1 : 0; c = cyc;
         end
      end
      chk("gnt_wait_timeout", got, 1);
   endtask

   task automatic wait_done(input int id, output int c);
      bit got = 0;
      c = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if ((id == 0 && bus.ctl_done0) || (id == 1 && bus.ctl_done1)) begin
            got = 1; c = cyc;
         end
      end
      chk("done_wait_timeout", got, 1);
   endtask

   task automatic wait_idle();
      bit got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 &&
             !bus.ctl_busy && !bus.ctl_req0 && !bus.ctl_req1) got = 1;
      end
      chk("idle_wait_timeout", got, 1);
   endtask

   initial begin
      int id, g, c, g2, g3, d0_before, ab_before;
      bus.ctl_rco = 8'h00;

      // Reset held two cycles with both requesters waiting.
      rst = 1'b1;
      push_cmd(0, 2'b00, 32'h0000_00A5, 8'd5);
      push_cmd(1, 2'b01, 32'h0000_0100, 8'd3);
      repeat (2) begin
         @(negedge clk);
         chk("rst_gnt",    {bus.ctl_gnt1, bus.ctl_gnt0}, 2'b00);
         chk("rst_busy",   bus.ctl_busy,   1'b0);
         chk("rst_enable", bus.ctl_enable, 1'b0);
         chk("rst_mode",   bus.ctl_mode,   2'b00);
         chk("rst_D",      bus.ctl_D,      32'h0);
      end
      rst = 1'b0;

      // First grant to requester 0; load then five counting cycles.
      wait_any_gnt(id, g);
      chk("first_owner", id, 0);
      chk("load_D",    bus.ctl_D,      32'h0000_00A5);
      chk("load_mode", bus.ctl_mode,   2'b11);
      chk("load_en",   bus.ctl_enable, 1'b1);
      @(negedge clk);
      chk("run_mode", bus.ctl_mode,   2'b00);
      chk("run_en",   bus.ctl_enable, 1'b1);
      wait_done(0, c);
      chk("len5_done_offset", c - g, 6);
      wait_any_gnt(id, g2);
      chk("second_owner", id, 1);
      chk("second_gnt_offset", g2 - g, 8);
      wait_idle();

      // Both held continuously: alternating owners, len 2 each.
      push_cmd(0, 2'b00, 32'h0000_1111, 8'd2);
      push_cmd(0, 2'b00, 32'h0000_3333, 8'd2);
      push_cmd(1, 2'b10, 32'h0000_2222, 8'd2);
      wait_any_gnt(id, g);
      chk("rr_a", id, 0);
      wait_any_gnt(id, g2);
      chk("rr_b", id, 1);
      chk("rr_gap_ab", g2 - g, 5);
      wait_any_gnt(id, g3);
      chk("rr_c", id, 0);
      chk("rr_gap_bc", g3 - g2, 5);
      wait_idle();

      // Parallel load mode skips counting; len 0 also skips counting.
      push_cmd(1, 2'b11, 32'hDEAD_BEEF, 8'd9);
      wait_any_gnt(id, g);
      chk("ld_owner", id, 1);
      chk("ld_D", bus.ctl_D, 32'hDEAD_BEEF);
      wait_done(1, c);
      chk("ld_done_offset", c - g, 1);
      wait_idle();
      push_cmd(0, 2'b10, 32'h0000_0055, 8'd0);
      wait_any_gnt(id, g);
      chk("len0_owner", id, 0);
      wait_done(0, c);
      chk("len0_done_offset", c - g, 1);
      wait_idle();

      // Reset in the third counting cycle; pending requester 1 served next.
      push_cmd(0, 2'b00, 32'h0000_0010, 8'd10);
      wait_any_gnt(id, g);
      @(negedge clk);
      push_cmd(1, 2'b01, 32'h0000_0077, 8'd1);
      @(negedge clk);
      @(negedge clk);
      d0_before = done0_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_enable", bus.ctl_enable, 1'b0);
      chk("rstmid_busy",   bus.ctl_busy,   1'b0);
      wait_any_gnt(id, g);
      chk("rstmid_next_owner", id, 1);
      wait_idle();
      chk("rstmid_no_done0", done0_cnt - d0_before, 0);

      // Ripple carry seen in the third counting cycle.
      push_cmd(0, 2'b00, 32'h0000_0000, 8'd10);
      ab_before = abort_cnt;
      wait_any_gnt(id, g);
      repeat (3) @(negedge clk);
      bus.ctl_rco = 8'h01;
      @(negedge clk);
      bus.ctl_rco = 8'h00;
      wait_done(0, c);
      wait_idle();
`ifdef CTL_RCO_ABORT_EN
      chk("rco_done_offset", c - g, 4);
      chk("rco_abort_pulses", abort_cnt - ab_before, 1);
`else
      chk("rco_done_offset", c - g, 11);
      chk("rco_abort_pulses", abort_cnt - ab_before, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
